// File: rtl/ddram_dl_pkg.sv
// Shared types for the download-to-DDRAM writer: FIFO entry layout, drain FSM states, pad byte.
package ddram_dl_pkg;

  typedef struct packed {
    logic [25:0] haddr;
    logic [15:0] data;
  } dl_entry_t;

  typedef enum logic [1:0] {
    SYNC,
    IDLE,
    WAIT
  } drain_state_t;

  localparam logic [7:0] PAD_BYTE = 8'h00;

endpackage

// File: rtl/ddram_dl_fifo.sv
// Show-ahead synchronous FIFO of download entries; rd_dat is valid whenever empty=0.
// A push while full is ignored unless a pop frees the slot in the same cycle.
module ddram_dl_fifo
  import ddram_dl_pkg::*;
#(
  parameter int FIFO_AW = 3
) (
  input  logic             clk_sys,
  input  logic             reset_n,
  input  logic             push,
  input  dl_entry_t        wr_dat,
  input  logic             pop,
  output dl_entry_t        rd_dat,
  output logic [FIFO_AW:0] count,
  output logic             full,
  output logic             empty
);

  localparam int DEPTH = 1 << FIFO_AW;

  dl_entry_t          mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr;
  logic [FIFO_AW-1:0] rd_ptr;
  logic               wr_en;
  logic               rd_en;

  assign full   = (count == DEPTH[FIFO_AW:0]);
  assign empty  = (count == '0);
  assign rd_en  = pop & ~empty;
  assign wr_en  = push & (~full | rd_en);
  assign rd_dat = mem[rd_ptr];

  always_ff @(posedge clk_sys) begin
    if (wr_en) mem[wr_ptr] <= wr_dat;
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ddram_dl_writer.sv
// Pairs HPS download bytes into little-endian halfwords and issues them over the we_req/we_ack toggle.
// Issue >=2 cycles after pairing; dl_wait registered (1 cycle). DDRAM_DL_CHECKSUM_EN adds a checksum port.
module ddram_dl_writer
  import ddram_dl_pkg::*;
#(
  parameter int          FIFO_AW   = 3,
  parameter int          WAIT_HWM  = 6,
  parameter logic [27:0] BASE_ADDR = 28'h0
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        dl_en,
  input  logic        dl_wr,
  input  logic [26:0] dl_addr,
  input  logic [7:0]  dl_data,
  output logic        dl_wait,
  output logic [27:0] wraddr,
  output logic [15:0] din,
  output logic        we_req,
  input  logic        we_ack,
  output logic        dl_done,
  output logic        overflow,
  output logic [27:0] byte_count
`ifdef DDRAM_DL_CHECKSUM_EN
  ,
  output logic [31:0] checksum
`endif
);

  localparam logic [FIFO_AW:0] HWM = WAIT_HWM[FIFO_AW:0];

  logic             dl_en_q, dl_rise, dl_fall, acc, held_ok;
  logic             held_vld, held_vld_nxt;
  logic [25:0]      held_haddr, held_haddr_nxt;
  logic [7:0]       held_byte, held_byte_nxt;
  logic             push_a_vld, push_b_vld, skid_vld, skid_vld_nxt;
  dl_entry_t        push_a, push_b, skid, skid_nxt;
  logic             fifo_push, fifo_pop, fifo_full, fifo_empty, drop;
  dl_entry_t        fifo_wdat, fifo_rdat;
  logic [FIFO_AW:0] fifo_count;
  drain_state_t     state, state_nxt;
  logic             req_nxt, issue, done_armed, done_cond;

  assign dl_rise = dl_en & ~dl_en_q;
  assign dl_fall = ~dl_en & dl_en_q;
  assign acc     = dl_en & dl_wr;
  assign held_ok = held_vld & ~dl_rise;  // a rising dl_en discards any stale low byte

  always_comb begin
    held_vld_nxt   = held_ok;
    held_haddr_nxt = held_haddr;
    held_byte_nxt  = held_byte;
    push_a_vld     = 1'b0;
    push_a         = {held_haddr, PAD_BYTE, held_byte};
    push_b_vld     = 1'b0;
    push_b         = {dl_addr[26:1], dl_data, PAD_BYTE};
    if (acc) begin
      if (!dl_addr[0]) begin
        push_a_vld     = held_ok;
        held_vld_nxt   = 1'b1;
        held_haddr_nxt = dl_addr[26:1];
        held_byte_nxt  = dl_data;
      end else begin
        held_vld_nxt = 1'b0;
        push_a_vld   = 1'b1;
        if (held_ok && held_haddr == dl_addr[26:1]) begin
          push_a.data = {dl_data, held_byte};
        end else if (held_ok) begin
          push_b_vld = 1'b1;
        end else begin
          push_a = push_b;
        end
      end
    end else if (dl_fall && held_vld) begin
      push_a_vld   = 1'b1;
      held_vld_nxt = 1'b0;
    end
  end

  // The skid always drains first; it can only refill while the holder is empty,
  // so a double push never meets an occupied skid.
  always_comb begin
    if (skid_vld) begin
      fifo_push    = 1'b1;
      fifo_wdat    = skid;
      skid_vld_nxt = push_a_vld;
      skid_nxt     = push_a;
    end else begin
      fifo_push    = push_a_vld;
      fifo_wdat    = push_a;
      skid_vld_nxt = push_b_vld;
      skid_nxt     = push_b;
    end
  end

  assign drop = fifo_push & fifo_full & ~fifo_pop;

  ddram_dl_fifo #(.FIFO_AW(FIFO_AW)) u_fifo (
    .clk_sys (clk_sys),
    .reset_n (reset_n),
    .push    (fifo_push),
    .wr_dat  (fifo_wdat),
    .pop     (fifo_pop),
    .rd_dat  (fifo_rdat),
    .count   (fifo_count),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  always_comb begin
    state_nxt = state;
    req_nxt   = we_req;
    issue     = 1'b0;
    case (state)
      SYNC: begin
        req_nxt   = we_ack;
        state_nxt = IDLE;
      end
      IDLE: if (!fifo_empty && we_req == we_ack) begin
        issue     = 1'b1;
        req_nxt   = ~we_req;
        state_nxt = WAIT;
      end
      WAIT: if (we_ack == we_req) state_nxt = IDLE;
      default: state_nxt = SYNC;
    endcase
  end

  assign fifo_pop  = issue;
  assign done_cond = done_armed & ~dl_en & ~held_vld & ~skid_vld & fifo_empty
                   & (state == IDLE) & (we_req == we_ack);

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      dl_en_q    <= 1'b0;
      held_vld   <= 1'b0;
      held_haddr <= '0;
      held_byte  <= '0;
      skid_vld   <= 1'b0;
      skid       <= '0;
      state      <= SYNC;
      we_req     <= 1'b0;
      wraddr     <= '0;
      din        <= '0;
      dl_wait    <= 1'b0;
      dl_done    <= 1'b0;
      done_armed <= 1'b0;
      overflow   <= 1'b0;
      byte_count <= '0;
    end else begin
      dl_en_q    <= dl_en;
      held_vld   <= held_vld_nxt;
      held_haddr <= held_haddr_nxt;
      held_byte  <= held_byte_nxt;
      skid_vld   <= skid_vld_nxt;
      skid       <= skid_nxt;
      state      <= state_nxt;
      we_req     <= req_nxt;
      if (issue) begin
        wraddr <= BASE_ADDR + {1'b0, fifo_rdat.haddr, 1'b0};
        din    <= fifo_rdat.data;
      end
      dl_wait    <= (fifo_count >= HWM) | skid_vld;
      dl_done    <= done_cond;
      done_armed <= dl_fall | (done_armed & ~done_cond);
      if (dl_rise)   overflow <= drop;
      else if (drop) overflow <= 1'b1;
      if (dl_rise)  byte_count <= acc ? 28'd1 : 28'd0;
      else if (acc) byte_count <= byte_count + 28'd1;
    end
  end

`ifdef DDRAM_DL_CHECKSUM_EN
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n)     checksum <= '0;
    else if (dl_rise) checksum <= acc ? {24'd0, dl_data} : 32'd0;
    else if (acc)     checksum <= checksum + {24'd0, dl_data};
  end
`endif

endmodule

// File: tb/tb_ddram_dl_writer.sv
// Directed bench for ddram_dl_writer: pairing, padding, base offset, backpressure, overflow, reset resync.
module tb_ddram_dl_writer;
  import ddram_dl_pkg::*;

  logic        clk_sys = 1'b0;
  logic        reset_n = 1'b0;
  logic        dl_en = 1'b0, dl_wr = 1'b0;
  logic [26:0] dl_addr = '0;
  logic [7:0]  dl_data = '0;
  logic        dl_wait, we_req, dl_done, overflow;
  logic        we_ack = 1'b0;
  logic [27:0] wraddr, byte_count;
  logic [15:0] din;
  logic        b_dl_wait, b_we_req, b_we_ack, b_dl_done, b_overflow;
  logic [27:0] b_wraddr, b_byte_count;
  logic [15:0] b_din;
`ifdef DDRAM_DL_CHECKSUM_EN
  logic [31:0] checksum, b_checksum;
`endif

  logic        ack_en = 1'b0, ack_rst_val = 1'b0;
  int          ack_dly = 0, done_cnt = 0;
  logic [27:0] wa_q[$];
  logic [15:0] wd_q[$];
  int          checks = 0, errors = 0;
  int          wb, db, sent;

  always #5 clk_sys = ~clk_sys;

  ddram_dl_writer #(.FIFO_AW(3), .WAIT_HWM(6), .BASE_ADDR(28'h0)) dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .dl_en(dl_en), .dl_wr(dl_wr), .dl_addr(dl_addr),
    .dl_data(dl_data), .dl_wait(dl_wait), .wraddr(wraddr), .din(din), .we_req(we_req),
    .we_ack(we_ack), .dl_done(dl_done), .overflow(overflow), .byte_count(byte_count)
`ifdef DDRAM_DL_CHECKSUM_EN
    , .checksum(checksum)
`endif
  );

  assign b_we_ack = b_we_req;
  ddram_dl_writer #(.FIFO_AW(3), .WAIT_HWM(6), .BASE_ADDR(28'h0200000)) u_base (
    .clk_sys(clk_sys), .reset_n(reset_n), .dl_en(dl_en), .dl_wr(dl_wr), .dl_addr(dl_addr),
    .dl_data(dl_data), .dl_wait(b_dl_wait), .wraddr(b_wraddr), .din(b_din), .we_req(b_we_req),
    .we_ack(b_we_ack), .dl_done(b_dl_done), .overflow(b_overflow), .byte_count(b_byte_count)
`ifdef DDRAM_DL_CHECKSUM_EN
    , .checksum(b_checksum)
`endif
  );

  // DDRAM model: completes a request three negedges after it appears and logs the committed write.
  always @(negedge clk_sys) begin
    if (dl_done) done_cnt++;
    if (!reset_n) begin
      we_ack  = ack_rst_val;
      ack_dly = 0;
    end else if (ack_en && we_req !== we_ack) begin
      if (ack_dly == 2) begin
        wa_q.push_back(wraddr);
        wd_q.push_back(din);
        we_ack  = we_req;
        ack_dly = 0;
      end else begin
        ack_dly++;
      end
    end else begin
      ack_dly = 0;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_wr(input string tag, input int idx, input logic [27:0] a, input logic [15:0] d);
    logic [27:0] ga;
    logic [15:0] gd;
    ga = 28'hfff_ffff;
    gd = 16'hdead;
    if (idx < wa_q.size()) begin
      ga = wa_q[idx];
      gd = wd_q[idx];
    end
    check({tag, "_addr"}, {4'h0, ga}, {4'h0, a});
    check({tag, "_data"}, {16'h0, gd}, {16'h0, d});
  endtask

  task automatic put(input logic [26:0] a, input logic [7:0] d);
    dl_addr = a;
    dl_data = d;
    dl_wr   = 1'b1;
    @(negedge clk_sys);
    dl_wr   = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int base);
    int n;
    n = 0;
    while (done_cnt == base && n < 300) begin
      @(negedge clk_sys);
      n++;
    end
    repeat (8) @(negedge clk_sys);
    check(tag, done_cnt - base, 1);
  endtask

  initial begin
    repeat (3) @(negedge clk_sys);
    reset_n = 1'b1;
    @(negedge clk_sys);
    check("rst_we_req", we_req, 0);
    check("rst_dl_wait", dl_wait, 0);
    check("rst_dl_done", dl_done, 0);
    check("rst_overflow", overflow, 0);
    check("rst_byte_count", byte_count, 0);
    check("rst_wraddr", wraddr, 0);
    check("rst_din", din, 0);

    // Basic four-byte download
    ack_en = 1'b1;
    wb = wa_q.size(); db = done_cnt;
    dl_en = 1'b1; @(negedge clk_sys);
    put(27'h0, 8'h11); put(27'h1, 8'h22); put(27'h2, 8'h33); put(27'h3, 8'h44);
    dl_en = 1'b0;
    wait_done("t1_done", db);
    check("t1_nwr", wa_q.size() - wb, 2);
    check_wr("t1_w0", wb, 28'h000, 16'h2211);
    check_wr("t1_w1", wb + 1, 28'h002, 16'h4433);
    check("t1_bytes", byte_count, 4);

    // Odd length: trailing byte padded at dl_en fall
    wb = wa_q.size(); db = done_cnt;
    dl_en = 1'b1; @(negedge clk_sys);
    put(27'h100, 8'hAA); put(27'h101, 8'hBB); put(27'h102, 8'hCC);
    dl_en = 1'b0;
    wait_done("t2_done", db);
    check("t2_nwr", wa_q.size() - wb, 2);
    check_wr("t2_w0", wb, 28'h100, 16'hBBAA);
    check_wr("t2_w1", wb + 1, 28'h102, 16'h00CC);
    check("t2_bytes", byte_count, 3);

    // Odd address not matching the held even byte: two pushes through the skid
    wb = wa_q.size(); db = done_cnt;
    dl_en = 1'b1; @(negedge clk_sys);
    put(27'h200, 8'h5A); put(27'h203, 8'h6B);
    dl_en = 1'b0;
    wait_done("t3_done", db);
    check("t3_nwr", wa_q.size() - wb, 2);
    check_wr("t3_w0", wb, 28'h200, 16'h005A);
    check_wr("t3_w1", wb + 1, 28'h202, 16'h6B00);

    // Base address offset on the second instance
    wb = wa_q.size(); db = done_cnt;
    dl_en = 1'b1; @(negedge clk_sys);
    put(27'h10, 8'h77); put(27'h11, 8'h88);
    dl_en = 1'b0;
    wait_done("t4_done", db);
    check_wr("t4_w0", wb, 28'h010, 16'h8877);
    check("t4_base_wraddr", b_wraddr, 28'h0200010);
    check("t4_base_din", b_din, 16'h8877);

    // Stalled DDRAM, source honours dl_wait
    ack_en = 1'b0;
    wb = wa_q.size(); db = done_cnt;
    dl_en = 1'b1; @(negedge clk_sys);
    sent = 0;
    for (int cyc = 0; cyc < 400 && sent < 20; cyc++) begin
      if (cyc == 40) begin
        check("t5_wait_high", dl_wait, 1);
        check("t5_bytes_stall", byte_count, 15);
        check("t5_ovf_stall", overflow, 0);
        ack_en = 1'b1;
      end
      if (!dl_wait) begin
        dl_addr = 27'h300 + 27'(sent);
        dl_data = 8'h40 + 8'(sent);
        dl_wr   = 1'b1;
        sent++;
      end else begin
        dl_wr = 1'b0;
      end
      @(negedge clk_sys);
    end
    dl_wr = 1'b0;
    dl_en = 1'b0;
    check("t5_sent", sent, 20);
    wait_done("t5_done", db);
    check("t5_nwr", wa_q.size() - wb, 10);
    check_wr("t5_first", wb, 28'h300, 16'h4140);
    check_wr("t5_last", wb + 9, 28'h312, 16'h5352);
    check("t5_ovf", overflow, 0);

    // Stalled DDRAM, source ignores dl_wait: the tenth pair is dropped
    ack_en = 1'b0;
    wb = wa_q.size(); db = done_cnt;
    dl_en = 1'b1; @(negedge clk_sys);
    for (int i = 0; i < 20; i++) put(27'(i), 8'h80 + 8'(i));
    dl_en = 1'b0;
    @(negedge clk_sys);
    check("t6_ovf", overflow, 1);
    check("t6_bytes", byte_count, 20);
    check("t6_wait", dl_wait, 1);
    ack_en = 1'b1;
    wait_done("t6_done", db);
    check("t6_nwr", wa_q.size() - wb, 9);
    check_wr("t6_first", wb, 28'h000, 16'h8180);
    check_wr("t6_last", wb + 8, 28'h010, 16'h9190);
    check("t6_ovf_sticky", overflow, 1);

    // dl_en rise clears counters; checksum when built in
    wb = wa_q.size(); db = done_cnt;
    dl_en = 1'b1; @(negedge clk_sys);
    check("t7_ovf_clr", overflow, 0);
    check("t7_bytes_clr", byte_count, 0);
    put(27'h400, 8'hFF); put(27'h401, 8'hFF); put(27'h402, 8'h01);
`ifdef DDRAM_DL_CHECKSUM_EN
    check("t7_checksum", checksum, 32'h0000_01FF);
`endif
    check("t7_bytes", byte_count, 3);
    dl_en = 1'b0;
    wait_done("t7_done", db);
    check_wr("t7_w1", wb + 1, 28'h402, 16'h0001);
    db = done_cnt;
    dl_en = 1'b1; @(negedge clk_sys); @(negedge clk_sys);
`ifdef DDRAM_DL_CHECKSUM_EN
    check("t7_checksum_clr", checksum, 0);
`endif
    check("t7_bytes_clr2", byte_count, 0);
    dl_en = 1'b0;
    wait_done("t7_done2", db);

    // Reset while a request is outstanding: SYNC realigns, no spurious write
    ack_en = 1'b0;
    dl_en = 1'b1; @(negedge clk_sys);
    put(27'h500, 8'hC1); put(27'h501, 8'hC2);
    dl_en = 1'b0;
    repeat (4) @(negedge clk_sys);
    check("t8_pending", we_req ^ we_ack, 1);
    ack_rst_val = 1'b1;
    reset_n = 1'b0;
    repeat (2) @(negedge clk_sys);
    check("t8_req_in_rst", we_req, 0);
    reset_n = 1'b1;
    wb = wa_q.size();
    ack_en = 1'b1;
    repeat (5) @(negedge clk_sys);
    check("t8_req_sync", we_req, 1);
    check("t8_no_spurious", wa_q.size() - wb, 0);
    db = done_cnt;
    dl_en = 1'b1; @(negedge clk_sys);
    put(27'h520, 8'h12); put(27'h521, 8'h34);
    dl_en = 1'b0;
    wait_done("t8_done", db);
    check("t8_nwr", wa_q.size() - wb, 1);
    check_wr("t8_w0", wb, 28'h520, 16'h3412);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
